ir_fetch_stage: RTL

Instruction-register stage for the 16-bit multi-cycle processor. Fetches one instruction word from memory over a request/acknowledge handshake, holds it in the IR, and registers the IR fields plus the shifter-control decode (ShifterInput, ShifterLeft, ShiftAmount) that drive the Extend/Shift unit directly downstream. Also provides a wait-state timeout fault and a retired-fetch counter.

---
 rtl/ir_fetch_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ir_fetch_stage.sv
// Instruction-register fetch stage: one memory read per Fetch over a req/ack
// handshake, IR capture, registered shifter-control decode, timeout fault and fetch counter.
module ir_fetch_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Fetch,
    input  logic [15:0] PC_In,
    input  logic        Consume,
    output logic        Mem_Req,
    output logic [15:0] Mem_Addr,
    input  logic        Mem_Ack,
    input  logic [15:0] Mem_Data,
    output logic [15:0] IR,
    output logic [3:0]  Opcode,
    output logic [3:0]  IR11_8,
    output logic [7:0]  IR7_0,
    output logic [3:0]  IR3_0,
    output logic [1:0]  ShifterInput,
    output logic        ShifterLeft,
    output logic [1:0]  ShiftAmount,
    output logic        Valid,
    output logic        Busy,
    output logic        Fault,
    output logic [15:0] FetchCount
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_DECODE = 2'd2,
        S_READY  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   ir_q, ir_d;
    logic [15:0]   fetch_cnt_q, fetch_cnt_d;
    logic [1:0]    sh_in_q, sh_in_d;
    logic          sh_left_q, sh_left_d;
    logic [1:0]    sh_amt_q, sh_amt_d;
    logic          fault_q, fault_d;
    logic          req_q, valid_q, busy_q;

    // Packed as {ShifterInput, ShifterLeft, ShiftAmount}.
    function automatic logic [4:0] shift_decode(input logic [3:0] op);
        logic [4:0] ctl;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: ctl = {2'b10, 1'b1, 2'b10};
            4'h4:                   ctl = {2'b10, 1'b1, 2'b01};
            4'h5:                   ctl = {2'b10, 1'b0, 2'b01};
            4'h6:                   ctl = {2'b01, 1'b1, 2'b10};
            4'h7:                   ctl = {2'b01, 1'b1, 2'b00};
            4'h8:                   ctl = {2'b00, 1'b1, 2'b10};
            4'h9:                   ctl = {2'b01, 1'b1, 2'b11};
            default:                ctl = {2'b11, 1'b1, 2'b10};
        endcase
        return ctl;
    endfunction

    // Next-state and datapath update logic for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        fetch_cnt_d = fetch_cnt_q;
        sh_in_d     = sh_in_q;
        sh_left_d   = sh_left_q;
        sh_amt_d    = sh_amt_q;
        fault_d     = fault_q;
        case (state_q)
            S_IDLE: begin
                if (Fetch) begin
                    addr_d  = PC_In;
                    wait_d  = {CW{1'b0}};
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (Mem_Ack) begin
                    ir_d    = Mem_Data;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d  = wait_q + CW'(1);
                end
            end
            S_DECODE: begin
                {sh_in_d, sh_left_d, sh_amt_d} = shift_decode(ir_q[15:12]);
                fetch_cnt_d = fetch_cnt_q + 16'd1;
                state_d     = S_READY;
            end
            S_READY: begin
                if (Consume && Fetch) begin
                    addr_d  = PC_In;
                    wait_d  = {CW{1'b0}};
                    state_d = S_REQ;
                end else if (Consume) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_READY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; status outputs are registered from the next state.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            wait_q      <= {CW{1'b0}};
            addr_q      <= 16'h0000;
            ir_q        <= 16'h0000;
            fetch_cnt_q <= 16'h0000;
            sh_in_q     <= 2'b00;
            sh_left_q   <= 1'b0;
            sh_amt_q    <= 2'b00;
            fault_q     <= 1'b0;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            ir_q        <= ir_d;
            fetch_cnt_q <= fetch_cnt_d;
            sh_in_q     <= sh_in_d;
            sh_left_q   <= sh_left_d;
            sh_amt_q    <= sh_amt_d;
            fault_q     <= fault_d;
            req_q       <= (state_d == S_REQ);
            valid_q     <= (state_d == S_READY);
            busy_q      <= (state_d == S_REQ) || (state_d == S_DECODE);
        end
    end

    assign Mem_Req      = req_q;
    assign Mem_Addr     = addr_q;
    assign IR           = ir_q;
    assign Opcode       = ir_q[15:12];
    assign IR11_8       = ir_q[11:8];
    assign IR7_0        = ir_q[7:0];
    assign IR3_0        = ir_q[3:0];
    assign ShifterInput = sh_in_q;
    assign ShifterLeft  = sh_left_q;
    assign ShiftAmount  = sh_amt_q;
    assign Valid        = valid_q;
    assign Busy         = busy_q;
    assign Fault        = fault_q;
    assign FetchCount   = fetch_cnt_q;

endmodule
